// File: rtl/start_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : start_dispatch
// Description : Queues tagged jobs and hands them to a worker one at a time,
//               watching for completion with a watchdog and reporting results.
// Revision    : 1.0 - initial release
// ============================================================================
module start_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        request__ENA,
    output logic        request__RDY,
    input  logic [7:0]  request_tag,
    output logic        startSignal__ENA,
    input  logic        startSignal__RDY,
    input  logic        busy,
    input  logic        busy__RDY,
    output logic        done__ENA,
    input  logic        done__RDY,
    output logic [7:0]  done_tag,
    output logic        done_timeout,
    output logic [15:0] issued_count,
    output logic        timeout_err
);

    localparam int                 c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [15:0]        c_WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_REPORT    = 3'd4
    } state_t;

    state_t             r_state;
    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic [15:0]        r_watchdog;
    logic [7:0]         r_jobTag;
    logic               r_doneEna;

    logic w_busy;
    logic w_push;
    logic w_pop;

    // An unqualified busy is ignored so a stale level cannot hold a job open.
    assign w_busy = busy & busy__RDY;

    assign request__RDY     = RST | (r_count < c_DEPTH);
    assign startSignal__ENA = ~RST & (r_state == S_ISSUE) & startSignal__RDY;
    assign done__ENA        = ~RST & r_doneEna;

    assign w_push = request__ENA & request__RDY;
    assign w_pop  = startSignal__ENA;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= request_tag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_watchdog   <= '0;
            r_jobTag     <= '0;
            r_doneEna    <= 1'b0;
            done_tag     <= '0;
            done_timeout <= 1'b0;
            issued_count <= '0;
            timeout_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (startSignal__RDY) begin
                        r_jobTag     <= r_mem[r_rdPtr];
                        issued_count <= issued_count + 16'd1;
                        r_state      <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    r_watchdog <= '0;
                    if (w_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        done_tag     <= r_jobTag;
                        done_timeout <= 1'b0;
                        r_doneEna    <= 1'b1;
                        r_state      <= S_REPORT;
                    end
                end
                S_WAIT_DONE: begin
                    if (!w_busy) begin
                        done_tag     <= r_jobTag;
                        done_timeout <= 1'b0;
                        r_doneEna    <= 1'b1;
                        r_state      <= S_REPORT;
                    end else if (r_watchdog == c_WD_LAST) begin
                        done_tag     <= r_jobTag;
                        done_timeout <= 1'b1;
                        timeout_err  <= 1'b1;
                        r_doneEna    <= 1'b1;
                        r_state      <= S_REPORT;
                    end else begin
                        r_watchdog <= r_watchdog + 16'd1;
                    end
                end
                S_REPORT: begin
                    if (done__RDY) begin
                        r_doneEna <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_doneEna <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
